fft_butterfly_r2: RTL and testbench
===================================

Name: fft_butterfly_r2

Overview:
- Pipelined radix-2 DIT butterfly, directly downstream of the complex multiplier.
- Consumes the top-leg sample A and the twiddled bottom-leg product W·B (the multiplier's packed output).
- Produces A+W·B and A−W·B.
- Valid/ready handshake on both sides, optional per-sample scale-by-½ for stage-wise FFT growth control, and a sticky overflow flag.

Parameters:
- DATA_W, 8, width of each real/imag component (signed two's complement); packed complex width is 2*DATA_W.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept input this cycle.
- i_A  in  2*DATA_W  top leg; packed {real[2*DATA_W-1:DATA_W], imag[DATA_W-1:0]}.
- i_WB  in  2*DATA_W  twiddled bottom leg, same packing as i_A.
- i_scale  in  1  1 = arithmetic shift right by 1 on both outputs for this sample.
- o_valid  out  1  output pair valid.
- i_ready  in  1  downstream accepts output.
- o_sum  out  2*DATA_W  A+W·B, packed.
- o_diff  out  2*DATA_W  A−W·B, packed.
- o_ovf  out  1  sticky overflow (saturation occurred).
- i_clr_ovf  in  1  synchronous clear of o_ovf.

Behaviour:
- Reset (async, i_rst_n=0):
  - All pipeline valids, o_valid, o_sum, o_diff and o_ovf go to 0 immediately.
  - o_ready=1 after reset release.
- Pipeline: two register stages.
  - S1 captures i_A, i_WB, i_scale.
  - S2 computes and registers o_sum/o_diff.
  - Latency: a sample accepted at edge N appears with o_valid=1 after edge N+2, provided there is no stall.
- Handshake:
  - en = ~o_valid | i_ready.
  - o_ready = en (combinational).
  - Transfer in when i_valid & o_ready; transfer out when o_valid & i_ready.
  - When en=0 all stages hold; o_sum/o_diff/o_valid remain stable; no sample is lost or duplicated; order is preserved.
  - Bubbles (S1 invalid) advance as invalid; only valid samples update S2 data.
- Arithmetic per component, real and imag independently:
  - Sign-extend to DATA_W+1 bits, then add/subtract exactly.
  - i_scale=1 (as captured with the sample): result = full-precision value >>> 1 (floor; e.g. −3 → −2). Never overflows.
  - i_scale=0: saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. [−128, 127] at default.
- o_ovf:
  - Set on any output transfer into S2 where any of the 4 components saturated.
  - Cleared by i_clr_ovf.
  - Set and clear in the same cycle: set wins (o_ovf=1).
  - Not affected by stalls.
- Reset mid-operation: in-flight samples are discarded; no partial output.

Test Plan:
- Basic, i_scale=0, i_ready=1: A=(10,3), WB=(5,−2) accepted at edge 0 -> after edge 2: o_valid=1, o_sum=(15,1), o_diff=(5,5), o_ovf=0.
- Scaling, i_scale=1: A=(100,−100), WB=(60,−60) -> o_sum=(80,−80), o_diff=(20,−20), o_ovf=0. Then A=(3,−3), WB=(0,0) -> o_sum=o_diff=(1,−2) (floor rounding).
- Saturation, i_scale=0: A=(100,−100), WB=(60,60) -> o_sum=(127,−40), o_diff=(40,−128), o_ovf=1, stays 1 over 5 idle cycles. Pulse i_clr_ovf -> o_ovf=0 next edge. i_clr_ovf high on the same edge as a saturating output -> o_ovf=1.
- Backpressure: stream 4 samples A=(k,0), WB=(1,0), k=1..4, hold i_ready=0 for 3 cycles once o_valid=1 -> o_ready=0 while stalled, o_sum held at (2,0). After release, o_sum=(2,0),(3,0),(4,0),(5,0) in order, none lost or duplicated.
- Bubbles: i_valid alternating 1/0 -> o_valid alternates with the same spacing 2 cycles later.
- Reset mid-stream: drop i_rst_n with 2 valid samples in flight -> o_valid, o_sum, o_diff and o_ovf are 0 without a clock edge. After release, no stale output appears and the next sample has latency 2.

Source files
------------

// File: rtl/fft_butterfly_r2_if.sv
// Handshake and data bundle for the radix-2 DIT butterfly.
// The slave modport is the butterfly's view; master is the driving environment.
interface fft_butterfly_r2_if #(
  parameter int DATA_W = 8
);
  logic                i_valid;
  logic                o_ready;
  logic [2*DATA_W-1:0] i_A;
  logic [2*DATA_W-1:0] i_WB;
  logic                i_scale;
  logic                o_valid;
  logic                i_ready;
  logic [2*DATA_W-1:0] o_sum;
  logic [2*DATA_W-1:0] o_diff;
  logic                o_ovf;
  logic                i_clr_ovf;

  modport slave (
    input  i_valid, i_A, i_WB, i_scale, i_ready, i_clr_ovf,
    output o_ready, o_valid, o_sum, o_diff, o_ovf
  );

  modport master (
    output i_valid, i_A, i_WB, i_scale, i_ready, i_clr_ovf,
    input  o_ready, o_valid, o_sum, o_diff, o_ovf
  );
endinterface

// File: rtl/fft_butterfly_r2.sv
// Two-stage radix-2 DIT butterfly: sum/diff of A and W*B with optional /2 scaling,
// saturation when unscaled, a sticky overflow flag and valid/ready flow control.
module fft_butterfly_r2 #(
  parameter int DATA_W = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fft_butterfly_r2_if.slave bus
);
  localparam int CW = 2 * DATA_W;

  // Returns {saturated, result}; the sum/difference is exact in DATA_W+1 bits.
  function automatic logic [DATA_W:0] bfly_comp(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              sub,
    input logic              scale
  );
    logic [DATA_W:0]   ext_a;
    logic [DATA_W:0]   ext_b;
    logic [DATA_W:0]   full;
    logic [DATA_W-1:0] res;
    logic              sat;
    ext_a = {a[DATA_W-1], a};
    ext_b = {b[DATA_W-1], b};
    full  = sub ? (ext_a - ext_b) : (ext_a + ext_b);
    sat   = 1'b0;
    if (scale) begin
      res = full[DATA_W:1];
    end else if (full[DATA_W] != full[DATA_W-1]) begin
      sat = 1'b1;
      res = full[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      res = full[DATA_W-1:0];
    end
    return {sat, res};
  endfunction

  logic          en_s;
  logic          v1_q, v1_d;
  logic [CW-1:0] a1_q, a1_d;
  logic [CW-1:0] wb1_q, wb1_d;
  logic          sc1_q, sc1_d;
  logic          o_valid_q, o_valid_d;
  logic [CW-1:0] o_sum_q, o_sum_d;
  logic [CW-1:0] o_diff_q, o_diff_d;
  logic          o_ovf_q, o_ovf_d;
  logic [DATA_W:0] sr_s, si_s, dr_s, di_s;
  logic          sat_s;

  // Whole pipeline advances only when the output slot is empty or being drained.
  always_comb begin
    en_s = ~o_valid_q | bus.i_ready;
  end

  // Stage 1: capture the incoming sample; bubbles advance as invalid.
  always_comb begin
    v1_d  = v1_q;
    a1_d  = a1_q;
    wb1_d = wb1_q;
    sc1_d = sc1_q;
    if (en_s) begin
      v1_d = bus.i_valid;
      if (bus.i_valid) begin
        a1_d  = bus.i_A;
        wb1_d = bus.i_WB;
        sc1_d = bus.i_scale;
      end else begin
        a1_d = a1_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Butterfly arithmetic on the stage-1 sample, real and imaginary parts independently.
  always_comb begin
    sr_s  = bfly_comp(a1_q[CW-1:DATA_W], wb1_q[CW-1:DATA_W], 1'b0, sc1_q);
    si_s  = bfly_comp(a1_q[DATA_W-1:0],  wb1_q[DATA_W-1:0],  1'b0, sc1_q);
    dr_s  = bfly_comp(a1_q[CW-1:DATA_W], wb1_q[CW-1:DATA_W], 1'b1, sc1_q);
    di_s  = bfly_comp(a1_q[DATA_W-1:0],  wb1_q[DATA_W-1:0],  1'b1, sc1_q);
    sat_s = sr_s[DATA_W] | si_s[DATA_W] | dr_s[DATA_W] | di_s[DATA_W];
  end

  // Stage 2: register results; overflow set takes priority over clear.
  always_comb begin
    o_valid_d = o_valid_q;
    o_sum_d   = o_sum_q;
    o_diff_d  = o_diff_q;
    if (en_s) begin
      o_valid_d = v1_q;
      if (v1_q) begin
        o_sum_d  = {sr_s[DATA_W-1:0], si_s[DATA_W-1:0]};
        o_diff_d = {dr_s[DATA_W-1:0], di_s[DATA_W-1:0]};
      end else begin
        o_sum_d = o_sum_q;
      end
    end else begin
      o_valid_d = o_valid_q;
    end
    o_ovf_d = (en_s & v1_q & sat_s) | (o_ovf_q & ~bus.i_clr_ovf);
  end

  // Pipeline and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q      <= 1'b0;
      a1_q      <= {CW{1'b0}};
      wb1_q     <= {CW{1'b0}};
      sc1_q     <= 1'b0;
      o_valid_q <= 1'b0;
      o_sum_q   <= {CW{1'b0}};
      o_diff_q  <= {CW{1'b0}};
      o_ovf_q   <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      a1_q      <= a1_d;
      wb1_q     <= wb1_d;
      sc1_q     <= sc1_d;
      o_valid_q <= o_valid_d;
      o_sum_q   <= o_sum_d;
      o_diff_q  <= o_diff_d;
      o_ovf_q   <= o_ovf_d;
    end
  end

  assign bus.o_ready = en_s;
  assign bus.o_valid = o_valid_q;
  assign bus.o_sum   = o_sum_q;
  assign bus.o_diff  = o_diff_q;
  assign bus.o_ovf   = o_ovf_q;
endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Directed bench for fft_butterfly_r2: hand-computed vectors checked with immediate assertions.
module tb_fft_butterfly_r2;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  fft_butterfly_r2_if #(.DATA_W(8)) bus ();

  fft_butterfly_r2 #(.DATA_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input int re, input int im);
    logic [7:0] r;
    logic [7:0] i;
    r = re[7:0];
    i = im[7:0];
    return {r, i};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int ar, input int ai, input int br, input int bi,
                       input logic sc);
    bus.i_valid = v;
    bus.i_A     = pk(ar, ai);
    bus.i_WB    = pk(br, bi);
    bus.i_scale = sc;
  endtask

  int pat[8];

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_A       = 16'h0000;
    bus.i_WB      = 16'h0000;
    bus.i_scale   = 1'b0;
    bus.i_ready   = 1'b1;
    bus.i_clr_ovf = 1'b0;
    #1;
    chk("rst_valid", bus.o_valid, 32'd0);
    chk("rst_sum",   bus.o_sum,   32'd0);
    chk("rst_diff",  bus.o_diff,  32'd0);
    chk("rst_ovf",   bus.o_ovf,   32'd0);
    #12 rst_n = 1'b1;
    step();
    chk("rst_ready", bus.o_ready, 32'd1);

    // Basic: sample presented after edge 0, captured at edge 1, output after edge 2.
    drive(1'b1, 10, 3, 5, -2, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    chk("basic_lat_valid", bus.o_valid, 32'd0);
    step();
    chk("basic_valid", bus.o_valid, 32'd1);
    chk("basic_sum",   bus.o_sum,  {16'd0, pk(15, 1)});
    chk("basic_diff",  bus.o_diff, {16'd0, pk(5, 5)});
    chk("basic_ovf",   bus.o_ovf,  32'd0);
    step();
    chk("basic_drain", bus.o_valid, 32'd0);

    // Scaling, back to back, including floor rounding of -3.
    drive(1'b1, 100, -100, 60, -60, 1'b1);
    step();
    drive(1'b1, 3, -3, 0, 0, 1'b1);
    step();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    chk("scale1_sum",  bus.o_sum,  {16'd0, pk(80, -80)});
    chk("scale1_diff", bus.o_diff, {16'd0, pk(20, -20)});
    chk("scale1_ovf",  bus.o_ovf,  32'd0);
    step();
    chk("scale2_valid", bus.o_valid, 32'd1);
    chk("scale2_sum",   bus.o_sum,  {16'd0, pk(1, -2)});
    chk("scale2_diff",  bus.o_diff, {16'd0, pk(1, -2)});
    step();

    // Saturation and sticky overflow.
    drive(1'b1, 100, -100, 60, 60, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    step();
    chk("sat_sum",  bus.o_sum,  {16'd0, pk(127, -40)});
    chk("sat_diff", bus.o_diff, {16'd0, pk(40, -128)});
    chk("sat_ovf",  bus.o_ovf,  32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat_ovf_sticky", bus.o_ovf, 32'd1);
    end
    bus.i_clr_ovf = 1'b1;
    step();
    bus.i_clr_ovf = 1'b0;
    chk("ovf_clear", bus.o_ovf, 32'd0);
    drive(1'b1, 100, -100, 60, 60, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    bus.i_clr_ovf = 1'b1;
    step();
    bus.i_clr_ovf = 1'b0;
    chk("ovf_set_wins", bus.o_ovf, 32'd1);
    bus.i_clr_ovf = 1'b1;
    step();
    bus.i_clr_ovf = 1'b0;
    chk("ovf_clear2", bus.o_ovf, 32'd0);

    // Backpressure: four samples, three stalled cycles once the first is out.
    drive(1'b1, 1, 0, 1, 0, 1'b0);
    step();
    drive(1'b1, 2, 0, 1, 0, 1'b0);
    step();
    drive(1'b1, 3, 0, 1, 0, 1'b0);
    bus.i_ready = 1'b0;
    #1;
    chk("bp_first", bus.o_sum, {16'd0, pk(2, 0)});
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", bus.o_ready, 32'd0);
      step();
      chk("bp_hold_sum",   bus.o_sum,   {16'd0, pk(2, 0)});
      chk("bp_hold_valid", bus.o_valid, 32'd1);
    end
    bus.i_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.o_ready, 32'd1);
    step();
    drive(1'b1, 4, 0, 1, 0, 1'b0);
    chk("bp_out2", bus.o_sum, {16'd0, pk(3, 0)});
    step();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    chk("bp_out3", bus.o_sum, {16'd0, pk(4, 0)});
    step();
    chk("bp_out4",   bus.o_sum,   {16'd0, pk(5, 0)});
    chk("bp_out4_v", bus.o_valid, 32'd1);
    step();
    chk("bp_no_dup", bus.o_valid, 32'd0);

    // Bubbles: valid pattern reappears two cycles after presentation.
    pat = '{1, 0, 1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      drive(pat[i] != 0, i, 0, 0, 0, 1'b0);
      step();
      if (i >= 1) begin
        chk("bubble_valid", bus.o_valid, pat[i-1]);
      end
    end

    // Reset with two samples in flight and overflow set.
    drive(1'b1, 100, 100, 100, 100, 1'b0);
    step();
    drive(1'b1, 90, 90, 90, 90, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    chk("mid_pre_ovf", bus.o_ovf, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.o_valid, 32'd0);
    chk("mid_rst_sum",   bus.o_sum,   32'd0);
    chk("mid_rst_diff",  bus.o_diff,  32'd0);
    chk("mid_rst_ovf",   bus.o_ovf,   32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("mid_no_stale1", bus.o_valid, 32'd0);
    step();
    chk("mid_no_stale2", bus.o_valid, 32'd0);
    drive(1'b1, 1, 1, 1, 1, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    chk("mid_lat1", bus.o_valid, 32'd0);
    step();
    chk("mid_lat2_valid", bus.o_valid, 32'd1);
    chk("mid_lat2_sum",   bus.o_sum,  {16'd0, pk(2, 2)});
    chk("mid_lat2_diff",  bus.o_diff, {16'd0, pk(0, 0)});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
